// File: rtl/prefetch_queue_pkg.sv
// Shared core definitions for the instruction prefetch queue: reset CS:IP,
// default queue depth, queue entry layout and the segment:offset address function.
package prefetch_queue_pkg;

    localparam int          PQ_DEPTH    = 4;
    localparam logic [15:0] PQ_RESET_CS = 16'hFFFF;
    localparam logic [15:0] PQ_RESET_IP = 16'h0000;

    typedef struct packed {
        logic [7:0]  data;
        logic [15:0] ip;
    } pq_entry_t;

    // Real-mode linear address; the 20-bit result drops the carry out of bit 19.
    function automatic logic [19:0] linear_addr(input logic [15:0] cs, input logic [15:0] ip);
        return {cs, 4'h0} + {4'h0, ip};
    endfunction

endpackage

// File: rtl/prefetch_queue_fifo.sv
// Byte+IP storage for the prefetch queue: circular buffer with push, pop,
// clear and an occupancy count derived from pointers one bit wider than the index.
module pq_fifo
    import prefetch_queue_pkg::*;
#(
    parameter int DEPTH = PQ_DEPTH,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic      clock_i,
    input  logic      reset_i,
    input  logic      clear_i,
    input  logic      push_i,
    input  pq_entry_t push_entry_i,
    input  logic      pop_i,
    output pq_entry_t head_o,
    output logic [PW:0] count_o
);

    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);
    localparam logic [PW:0] ONE  = (PW + 1)'(1);

    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    pq_entry_t   mem_q [DEPTH];
    logic        do_push, do_pop;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[PW-1:0]];
    assign do_pop  = pop_i && (count_o != '0);
    assign do_push = push_i && ((count_o != FULL) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + ONE;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clock_i) begin
        if (do_push && !clear_i && !reset_i) begin
            mem_q[wr_ptr_q[PW-1:0]] <= push_entry_i;
        end
    end

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: issues byte reads at CS:IP while space is reserved,
// captures each returned byte one cycle later and hands bytes to the decoder in order.
module prefetch_queue
    import prefetch_queue_pkg::*;
#(
    parameter int          DEPTH    = PQ_DEPTH,
    parameter logic [15:0] RESET_CS = PQ_RESET_CS,
    parameter logic [15:0] RESET_IP = PQ_RESET_IP
) (
    input  logic        clock,
    input  logic        reset,
    output logic [19:0] mem_address,
    output logic        mem_req,
    input  logic [7:0]  mem_data,
    input  logic        bus_busy,
    input  logic        flush,
    input  logic [15:0] flush_cs,
    input  logic [15:0] flush_ip,
    output logic [7:0]  q_data,
    output logic [15:0] q_ip,
    output logic        q_valid,
    input  logic        q_ready
);

    localparam int PW = $clog2(DEPTH);

    logic [15:0] fetch_cs_q, fetch_cs_d;
    logic [15:0] fetch_ip_q, fetch_ip_d;
    logic [15:0] inflight_ip_q, inflight_ip_d;
    logic        inflight_q, inflight_d;
    logic [PW:0]   count;
    logic [PW+1:0] occupancy;
    pq_entry_t     head, push_entry;
    logic          push, pop;

    // The inflight byte is counted so a request never issues without a free slot.
    assign occupancy   = {1'b0, count} + {{(PW + 1){1'b0}}, inflight_q};
    assign mem_address = linear_addr(fetch_cs_q, fetch_ip_q);
    assign mem_req     = !reset && !flush && !bus_busy && (occupancy < (PW + 2)'(DEPTH));
    assign q_valid     = (count != '0);
    assign q_data      = head.data;
    assign q_ip        = head.ip;
    assign push        = inflight_q && !flush;
    assign pop         = q_valid && q_ready && !flush;
    assign push_entry  = '{data: mem_data, ip: inflight_ip_q};

    pq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock_i      (clock),
        .reset_i      (reset),
        .clear_i      (flush),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (count)
    );

    always_comb begin
        fetch_cs_d    = fetch_cs_q;
        fetch_ip_d    = fetch_ip_q;
        inflight_d    = mem_req;
        inflight_ip_d = fetch_ip_q;
        if (flush) begin
            fetch_cs_d = flush_cs;
            fetch_ip_d = flush_ip;
            inflight_d = 1'b0;
        end else if (mem_req) begin
            fetch_ip_d = fetch_ip_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_cs_q    <= RESET_CS;
            fetch_ip_q    <= RESET_IP;
            inflight_q    <= 1'b0;
            inflight_ip_q <= '0;
        end else begin
            fetch_cs_q    <= fetch_cs_d;
            fetch_ip_q    <= fetch_ip_d;
            inflight_q    <= inflight_d;
            inflight_ip_q <= inflight_ip_d;
        end
    end

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue: directed scenarios plus a random phase,
// compared every cycle against a queue-based reference model.
module tb_prefetch_queue;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] mem_address;
    logic        mem_req;
    logic [7:0]  mem_data = '0;
    logic        bus_busy = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] flush_cs = '0;
    logic [15:0] flush_ip = '0;
    logic [7:0]  q_data;
    logic [15:0] q_ip;
    logic        q_valid;
    logic        q_ready = 1'b0;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] ip;
    } ent_t;

    ent_t        mq[$];
    bit          mPend = 1'b0;
    logic [19:0] mPendAddr = '0;
    logic [15:0] mPendIp = '0;
    logic [15:0] mCs = 16'hFFFF;
    logic [15:0] mIp = 16'h0000;
    int          testCount = 0;
    int          failCount = 0;

    prefetch_queue #(.DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_address (mem_address),
        .mem_req     (mem_req),
        .mem_data    (mem_data),
        .bus_busy    (bus_busy),
        .flush       (flush),
        .flush_cs    (flush_cs),
        .flush_ip    (flush_ip),
        .q_data      (q_data),
        .q_ip        (q_ip),
        .q_valid     (q_valid),
        .q_ready     (q_ready)
    );

    always #5 clock = ~clock;

    // Memory image: the boot bytes at FFFF0.. then an address-derived pattern.
    function automatic logic [7:0] byteAt(input logic [19:0] a);
        case (a)
            20'hFFFF0: return 8'hEA;
            20'hFFFF1: return 8'h00;
            20'hFFFF2: return 8'h01;
            default:   return a[7:0] ^ a[15:8] ^ {a[19:16], a[3:0]} ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [19:0] expAddress();
        int lin;
        lin = int'(mCs) * 16 + int'(mIp);
        return 20'(lin % (1 << 20));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model.
    task automatic applyStimulus(input bit rst, input bit fl, input logic [15:0] fcs,
                                 input logic [15:0] fip, input bit busy, input bit rdy);
        bit          expReq;
        logic [19:0] addr;
        @(negedge clock);
        reset    = rst;
        flush    = fl;
        flush_cs = fcs;
        flush_ip = fip;
        bus_busy = busy;
        q_ready  = rdy;
        mem_data = mPend ? byteAt(mPendAddr) : 8'($urandom);
        #1;
        addr   = expAddress();
        expReq = !rst && !fl && !busy && (mq.size() + int'(mPend) < DEPTH);
        checkOutput("mem_req", 32'(mem_req), 32'(expReq));
        if (!rst) checkOutput("mem_address", 32'(mem_address), 32'(addr));
        checkOutput("q_valid", 32'(q_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            checkOutput("q_data", 32'(q_data), 32'(mq[0].data));
            checkOutput("q_ip", 32'(q_ip), 32'(mq[0].ip));
        end
        @(posedge clock);
        if (rst) begin
            mq.delete();
            mPend = 1'b0;
            mCs   = 16'hFFFF;
            mIp   = 16'h0000;
        end else if (fl) begin
            mq.delete();
            mPend = 1'b0;
            mCs   = fcs;
            mIp   = fip;
        end else begin
            if (mq.size() > 0 && rdy) void'(mq.pop_front());
            if (mPend) mq.push_back('{byteAt(mPendAddr), mPendIp});
            mPend = expReq;
            if (expReq) begin
                mPendAddr = addr;
                mPendIp   = mIp;
                mIp       = mIp + 16'd1;
            end
        end
    endtask

    initial begin
        bit rst, fl, busy, rdy;
        logic [15:0] fcs, fip;

        reset = 1'b1;
        repeat (2) @(posedge clock);
        repeat (2) applyStimulus(1, 0, 16'h0, 16'h0, 0, 0);

        // Boot fetch with the decoder stalled: queue fills with EA,00,01,..
        repeat (8) applyStimulus(0, 0, 16'h0, 16'h0, 0, 0);
        #1;
        checkOutput("boot_head_data", 32'(q_data), 32'h0000_00EA);
        checkOutput("boot_head_ip", 32'(q_ip), 32'h0000_0000);
        checkOutput("boot_stop_addr", 32'(mem_address), 32'h000F_FFF4);

        // Decoder drains continuously.
        repeat (12) applyStimulus(0, 0, 16'h0, 16'h0, 0, 1);

        // Redirect while a byte is inflight.
        applyStimulus(0, 1, 16'h0000, 16'h7C00, 0, 1);
        #1;
        checkOutput("flush_qvalid", 32'(q_valid), 32'h0);
        checkOutput("flush_addr", 32'(mem_address), 32'h0000_7C00);
        repeat (6) applyStimulus(0, 0, 16'h0, 16'h0, 0, 0);

        // IP wrap with no carry into CS.
        applyStimulus(0, 1, 16'h1000, 16'hFFFF, 0, 0);
        #1;
        checkOutput("wrap_addr0", 32'(mem_address), 32'h0001_FFFF);
        repeat (4) applyStimulus(0, 0, 16'h0, 16'h0, 0, 0);
        repeat (5) applyStimulus(0, 0, 16'h0, 16'h0, 0, 1);

        // Bus stolen for three cycles right after a request issues.
        applyStimulus(0, 1, 16'h2000, 16'h0100, 0, 1);
        applyStimulus(0, 0, 16'h0, 16'h0, 0, 0);
        repeat (3) applyStimulus(0, 0, 16'h0, 16'h0, 1, 0);
        repeat (6) applyStimulus(0, 0, 16'h0, 16'h0, 0, 1);

        // Flush coinciding with a pop and an inflight return.
        repeat (3) applyStimulus(0, 0, 16'h0, 16'h0, 0, 0);
        applyStimulus(0, 1, 16'h3000, 16'h0000, 0, 1);
        repeat (4) applyStimulus(0, 0, 16'h0, 16'h0, 0, 1);

        // Reset mid-stream discards the inflight byte and queue.
        applyStimulus(1, 0, 16'h0, 16'h0, 0, 0);
        repeat (6) applyStimulus(0, 0, 16'h0, 16'h0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 99) == 0);
            fl   = ($urandom_range(0, 14) == 0);
            busy = ($urandom_range(0, 3) == 0);
            rdy  = ($urandom_range(0, 1) == 1);
            fcs  = 16'($urandom);
            fip  = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            applyStimulus(rst, fl, fcs, fip, busy, rdy);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
